// File: rtl/imem_pkg.sv
// Shared definitions for the bootable instruction memory: FSM state
// encoding, default parameter values and a word-alignment helper.
package imem_pkg;

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // addi x0,x0,0 -- returned for any faulted fetch
   localparam logic [31:0] NOP_INST_DEFAULT  = 32'h0000_0013;
   localparam int unsigned MEM_NBYTE_DEFAULT = 4096;

   // Clear the two byte-offset bits so the address names a whole word.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/imem_ram.sv
// Word-wide storage built from four byte lanes. Lane gi holds byte gi of
// each word, so byte address 4*idx+gi maps to lane gi (little-endian).
// One word write port and one synchronous word read port; no reset on
// the contents or on the read register so the arrays map onto block RAM.
module imem_ram #(
   parameter int unsigned NWORDS = 1024,
   parameter int unsigned AW     = 10
)(
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_idx,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_idx,
   output logic [31:0]   rd_data
);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [NWORDS];
         logic [7:0] rd_byte_reg;

         // Byte-lane write and registered read; read data only moves on rd_en
         always_ff @(posedge clk) begin
            if (wr_en) begin
               lane_mem[wr_idx] <= wr_data[8*gi +: 8];
            end
            if (rd_en) begin
               rd_byte_reg <= lane_mem[rd_idx];
            end
         end

         assign rd_data[8*gi +: 8] = rd_byte_reg;
      end
   endgenerate

endmodule

// File: rtl/imem_boot.sv
// Bootable instruction memory. After reset it takes a program as a stream
// of 32-bit words (LOAD), then serves fetches with one-cycle latency over a
// valid/ready request/response port (RUN). Only reset returns it to LOAD.
//
// Optional feature macro: IMEM_MISALIGN_CHECK_EN
//   defined     : a fetch with i_req_addr[1:0] != 0 faults (err=1, NOP).
//   not defined : i_req_addr[1:0] is ignored and the fetch is word-aligned.
module imem_boot
   import imem_pkg::*;
#(
   parameter int unsigned MEM_NBYTE = MEM_NBYTE_DEFAULT,
   parameter logic [31:0] NOP_INST  = NOP_INST_DEFAULT
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_ld_valid,
   output logic        o_ld_ready,
   input  logic [31:0] i_ld_data,
   input  logic        i_ld_last,
   output logic        o_boot_done,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_req_addr,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_inst,
   output logic        o_rsp_err
);

   localparam int unsigned   NWORDS    = MEM_NBYTE / 4;
   localparam int unsigned   AW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [31:0]   LAST_ADDR = 32'(MEM_NBYTE - 4);
   localparam logic [AW-1:0] LAST_WIDX = AW'(NWORDS - 1);

   state_t        state_reg, state_next;
   logic [AW-1:0] wcnt_reg, wcnt_next;
   logic          rsp_valid_reg;
   logic          rsp_err_reg;
   // Set by the first accepted fetch; keeps o_rsp_inst at 0 until then,
   // since the RAM read register itself has no reset.
   logic          rsp_loaded_reg;

   logic          ld_fire;
   logic          req_fire;
   logic [31:0]   fetch_addr;
   logic          fetch_err;
   logic [31:0]   ram_rd_data;

   // State and word-counter registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg <= ST_LOAD;
         wcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
      end
   end

   // Next state, load acceptance and handshake outputs
   always_comb begin
      state_next  = state_reg;
      wcnt_next   = wcnt_reg;
      o_ld_ready  = 1'b0;
      o_boot_done = 1'b0;
      o_req_ready = 1'b0;
      ld_fire     = 1'b0;
      case (state_reg)
         ST_LOAD: begin
            o_ld_ready = 1'b1;
            ld_fire    = i_ld_valid;
            if (i_ld_valid) begin
               // The final slot ends loading even without i_ld_last, so the
               // counter never wraps back onto word 0.
               if (i_ld_last || (wcnt_reg == LAST_WIDX)) begin
                  state_next = ST_RUN;
               end else begin
                  wcnt_next = wcnt_reg + AW'(1);
               end
            end
         end
         ST_RUN: begin
            o_boot_done = 1'b1;
            o_req_ready = !rsp_valid_reg || i_rsp_ready;
         end
         default: begin
            state_next = ST_LOAD;
         end
      endcase
   end

   assign req_fire = o_req_ready && i_req_valid;

`ifdef IMEM_MISALIGN_CHECK_EN
   assign fetch_addr = i_req_addr;
   assign fetch_err  = (i_req_addr[1:0] != 2'b00) || (i_req_addr > LAST_ADDR);
`else
   assign fetch_addr = word_align(i_req_addr);
   assign fetch_err  = (fetch_addr > LAST_ADDR);
`endif

   imem_ram #(
      .NWORDS (NWORDS),
      .AW     (AW)
   ) u_ram (
      .clk     (i_clk),
      .wr_en   (ld_fire),
      .wr_idx  (wcnt_reg),
      .wr_data (i_ld_data),
      .rd_en   (req_fire && !fetch_err),
      .rd_idx  (fetch_addr[AW+1:2]),
      .rd_data (ram_rd_data)
   );

   // Response register: loads on an accepted fetch, clears when retired
   // without a replacement, and holds while the consumer stalls.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rsp_valid_reg  <= 1'b0;
         rsp_err_reg    <= 1'b0;
         rsp_loaded_reg <= 1'b0;
      end else if (req_fire) begin
         rsp_valid_reg  <= 1'b1;
         rsp_err_reg    <= fetch_err;
         rsp_loaded_reg <= 1'b1;
      end else if (i_rsp_ready) begin
         rsp_valid_reg  <= 1'b0;
      end
   end

   assign o_rsp_valid = rsp_valid_reg;
   assign o_rsp_err   = rsp_err_reg;
   assign o_rsp_inst  = !rsp_loaded_reg ? 32'h0000_0000 :
                        rsp_err_reg     ? NOP_INST      : ram_rd_data;

endmodule
